dcache_mem_controller: RTL and testbench

- Downstream stage of dcache: takes the per-consumer miss/writeback requests dcache presents on its controller_* side and multiplexes them onto NUM_CHANNELS external memory channels.
- Each channel runs an independent transaction FSM.
- Channels claim pending consumers by fixed priority, and each consumer is served by at most one channel at a time.
- Responses are relayed back to the dcache with a valid/ready handshake.

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/mem_ctrl_channel.sv | 121 ++++++++++++
 rtl/dcache_mem_controller.sv | 157 +++++++++++++++
 tb/tb_dcache_mem_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the dcache memory controller and its per-channel FSMs.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        CH_IDLE           = 3'd0,
        CH_READ_WAITING   = 3'd1,
        CH_WRITE_WAITING  = 3'd2,
        CH_READ_RELAYING  = 3'd3,
        CH_WRITE_RELAYING = 3'd4
    } channel_state_t;

    localparam int DEFAULT_NUM_CONSUMERS = 8;
    localparam int CONSUMER_IDX_BITS     = $clog2(DEFAULT_NUM_CONSUMERS);

    // A single-consumer build still needs a 1-bit index register.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_ctrl_channel.sv
// One external memory channel: transaction FSM plus the latched consumer index,
// address and write data of the request it is currently serving.
module mem_ctrl_channel
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int IDX_BITS     = CONSUMER_IDX_BITS,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 claim_read,
    input  logic                 claim_write,
    input  logic [IDX_BITS-1:0]  claim_consumer,
    input  logic [ADDR_BITS-1:0] claim_address,
    input  logic [DATA_BITS-1:0] claim_data,
    input  logic                 cur_read_valid,
    input  logic                 cur_write_valid,
    input  logic                 mem_read_ready,
    input  logic                 mem_write_ready,
    output channel_state_t       state,
    output logic [IDX_BITS-1:0]  current_consumer,
    output logic                 read_done,
    output logic                 write_done,
    output logic                 read_release,
    output logic                 write_release,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data
);

    channel_state_t       state_next;
    logic [IDX_BITS-1:0]  consumer_next;
    logic                 read_valid_next;
    logic [ADDR_BITS-1:0] read_address_next;
    logic                 write_valid_next;
    logic [ADDR_BITS-1:0] write_address_next;
    logic [DATA_BITS-1:0] write_data_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= CH_IDLE;
            current_consumer  <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
        end else begin
            state             <= state_next;
            current_consumer  <= consumer_next;
            mem_read_valid    <= read_valid_next;
            mem_read_address  <= read_address_next;
            mem_write_valid   <= write_valid_next;
            mem_write_address <= write_address_next;
            mem_write_data    <= write_data_next;
        end
    end

    // Memory ready is only looked at while WAITING, so stray pulses elsewhere are ignored.
    always_comb begin
        state_next         = state;
        consumer_next      = current_consumer;
        read_valid_next    = mem_read_valid;
        read_address_next  = mem_read_address;
        write_valid_next   = mem_write_valid;
        write_address_next = mem_write_address;
        write_data_next    = mem_write_data;
        read_done          = 1'b0;
        write_done         = 1'b0;
        read_release       = 1'b0;
        write_release      = 1'b0;
        case (state)
            CH_IDLE: begin
                if (claim_read) begin
                    state_next        = CH_READ_WAITING;
                    consumer_next     = claim_consumer;
                    read_valid_next   = 1'b1;
                    read_address_next = claim_address;
                end else if (claim_write && (WRITE_ENABLE != 0)) begin
                    state_next         = CH_WRITE_WAITING;
                    consumer_next      = claim_consumer;
                    write_valid_next   = 1'b1;
                    write_address_next = claim_address;
                    write_data_next    = claim_data;
                end
            end
            CH_READ_WAITING: begin
                if (mem_read_ready) begin
                    state_next      = CH_READ_RELAYING;
                    read_valid_next = 1'b0;
                    read_done       = 1'b1;
                end
            end
            CH_WRITE_WAITING: begin
                if (mem_write_ready) begin
                    state_next       = CH_WRITE_RELAYING;
                    write_valid_next = 1'b0;
                    write_done       = 1'b1;
                end
            end
            CH_READ_RELAYING: begin
                if (!cur_read_valid) begin
                    state_next   = CH_IDLE;
                    read_release = 1'b1;
                end
            end
            CH_WRITE_RELAYING: begin
                if (!cur_write_valid) begin
                    state_next    = CH_IDLE;
                    write_release = 1'b1;
                end
            end
            default: state_next = CH_IDLE;
        endcase
    end

endmodule

// File: rtl/dcache_mem_controller.sv
// Multiplexes dcache miss/writeback requests onto NUM_CHANNELS memory channels,
// with fixed-priority claiming and a serving mask so no consumer is served twice.
module dcache_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 8,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

    localparam int CIDX = idx_bits(NUM_CONSUMERS);

    channel_state_t          ch_state       [NUM_CHANNELS];
    logic [CIDX-1:0]         ch_consumer    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ch_read_done;
    logic [NUM_CHANNELS-1:0] ch_write_done;
    logic [NUM_CHANNELS-1:0] ch_read_release;
    logic [NUM_CHANNELS-1:0] ch_write_release;
    logic [NUM_CHANNELS-1:0] ch_cur_read_valid;
    logic [NUM_CHANNELS-1:0] ch_cur_write_valid;

    logic [NUM_CHANNELS-1:0] claim_read;
    logic [NUM_CHANNELS-1:0] claim_write;
    logic [CIDX-1:0]         claim_consumer [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]    claim_address  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    claim_data     [NUM_CHANNELS];

    logic [NUM_CONSUMERS-1:0] serving;
    logic [NUM_CONSUMERS-1:0] pending;

    assign pending = consumer_read_valid
                   | ((WRITE_ENABLE != 0) ? consumer_write_valid : '0);

    // Cascaded scan: each idle channel takes the lowest pending consumer that is neither
    // being served nor already taken by a lower-indexed channel this cycle.
    always_comb begin
        logic [NUM_CONSUMERS-1:0] taken;
        logic                     found;
        taken       = serving;
        found       = 1'b0;
        claim_read  = '0;
        claim_write = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            claim_consumer[ch] = '0;
            claim_address[ch]  = '0;
            claim_data[ch]     = '0;
            found              = 1'b0;
            if (ch_state[ch] == CH_IDLE) begin
                for (int c = 0; c < NUM_CONSUMERS; c++) begin
                    if (!found && pending[c] && !taken[c]) begin
                        found              = 1'b1;
                        taken[c]           = 1'b1;
                        claim_consumer[ch] = CIDX'(c);
                        if (consumer_read_valid[c]) begin
                            claim_read[ch]    = 1'b1;
                            claim_address[ch] = consumer_read_address[c];
                        end else begin
                            claim_write[ch]   = 1'b1;
                            claim_address[ch] = consumer_write_address[c];
                            claim_data[ch]    = consumer_write_data[c];
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_channel
        assign ch_cur_read_valid[g]  = consumer_read_valid[ch_consumer[g]];
        assign ch_cur_write_valid[g] = consumer_write_valid[ch_consumer[g]];

        mem_ctrl_channel #(
            .ADDR_BITS    (ADDR_BITS),
            .DATA_BITS    (DATA_BITS),
            .IDX_BITS     (CIDX),
            .WRITE_ENABLE (WRITE_ENABLE)
        ) u_channel (
            .clk               (clk),
            .reset             (reset),
            .claim_read        (claim_read[g]),
            .claim_write       (claim_write[g]),
            .claim_consumer    (claim_consumer[g]),
            .claim_address     (claim_address[g]),
            .claim_data        (claim_data[g]),
            .cur_read_valid    (ch_cur_read_valid[g]),
            .cur_write_valid   (ch_cur_write_valid[g]),
            .mem_read_ready    (mem_read_ready[g]),
            .mem_write_ready   (mem_write_ready[g]),
            .state             (ch_state[g]),
            .current_consumer  (ch_consumer[g]),
            .read_done         (ch_read_done[g]),
            .write_done        (ch_write_done[g]),
            .read_release      (ch_read_release[g]),
            .write_release     (ch_write_release[g]),
            .mem_read_valid    (mem_read_valid[g]),
            .mem_read_address  (mem_read_address[g]),
            .mem_write_valid   (mem_write_valid[g]),
            .mem_write_address (mem_write_address[g]),
            .mem_write_data    (mem_write_data[g])
        );
    end

    // Consumers touched by different channels are always distinct, so per-channel
    // updates in one loop never collide on the same consumer bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            serving              <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (ch_read_release[ch] || ch_write_release[ch]) begin
                    serving[ch_consumer[ch]] <= 1'b0;
                end
                if (claim_read[ch] || claim_write[ch]) begin
                    serving[claim_consumer[ch]] <= 1'b1;
                end
                if (ch_read_done[ch]) begin
                    consumer_read_ready[ch_consumer[ch]] <= 1'b1;
                    consumer_read_data[ch_consumer[ch]]  <= mem_read_data[ch];
                end
                if (ch_read_release[ch]) begin
                    consumer_read_ready[ch_consumer[ch]] <= 1'b0;
                end
                if ((WRITE_ENABLE != 0) && ch_write_done[ch]) begin
                    consumer_write_ready[ch_consumer[ch]] <= 1'b1;
                end
                if (ch_write_release[ch]) begin
                    consumer_write_ready[ch_consumer[ch]] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_mem_controller.sv
// Self-checking bench for dcache_mem_controller; the bench plays the memory and keeps
// a simple byte-array model of its contents.
module tb_dcache_mem_controller;

    localparam int ADDR_BITS     = 8;
    localparam int DATA_BITS     = 8;
    localparam int NUM_CONSUMERS = 8;
    localparam int NUM_CHANNELS  = 4;

    logic                                    clk = 1'b0;
    logic                                    reset;
    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;
    logic [NUM_CHANNELS-1:0]                 mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]                 mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_ready;

    logic [DATA_BITS-1:0] mem_model [256];
    logic [ADDR_BITS-1:0] req_addr  [NUM_CONSUMERS];
    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dcache_mem_controller #(
        .ADDR_BITS     (ADDR_BITS),
        .DATA_BITS     (DATA_BITS),
        .NUM_CONSUMERS (NUM_CONSUMERS),
        .NUM_CHANNELS  (NUM_CHANNELS),
        .WRITE_ENABLE  (1)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int c, input logic rv, input logic [7:0] ra,
                                 input logic wv, input logic [7:0] wa, input logic [7:0] wd);
        consumer_read_valid[c]    = rv;
        consumer_read_address[c]  = ra;
        consumer_write_valid[c]   = wv;
        consumer_write_address[c] = wa;
        consumer_write_data[c]    = wd;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_rd_ready"},  32'(consumer_read_ready),  32'd0);
        checkOutput({tag, "_wr_ready"},  32'(consumer_write_ready), 32'd0);
        checkOutput({tag, "_mem_rd_v"},  32'(mem_read_valid),       32'd0);
        checkOutput({tag, "_mem_wr_v"},  32'(mem_write_valid),      32'd0);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] d;
        int         c;
        int         lat;
        logic       is_write;

        reset                  = 1'b1;
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        mem_read_ready         = '0;
        mem_read_data          = '0;
        mem_write_ready        = '0;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);

        // Reset state, then idle after release
        tick(2);
        checkQuiet("reset");
        checkOutput("reset_data_addr", 32'(|{consumer_read_data, mem_read_address,
                                              mem_write_address, mem_write_data}), 32'd0);
        reset = 1'b0;
        tick(3);
        checkQuiet("idle_after_reset");

        // Consumer 3 reads 0x2A, memory answers 0x5C
        applyStimulus(3, 1'b1, 8'h2A, 1'b0, 8'h00, 8'h00);
        tick();
        checkOutput("c3_mem_rd_v",  32'(mem_read_valid),      32'h1);
        checkOutput("c3_mem_addr",  32'(mem_read_address[0]), 32'h2A);
        checkOutput("c3_rd_ready0", 32'(consumer_read_ready), 32'h0);
        tick();
        checkOutput("c3_mem_rd_hold", 32'(mem_read_valid[0]), 32'h1);
        mem_read_ready[0] = 1'b1;
        mem_read_data[0]  = 8'h5C;
        tick();
        mem_read_ready[0] = 1'b0;
        checkOutput("c3_rd_ready",  32'(consumer_read_ready),   32'h08);
        checkOutput("c3_rd_data",   32'(consumer_read_data[3]), 32'h5C);
        checkOutput("c3_mem_rd_v0", 32'(mem_read_valid),        32'h0);
        tick();
        checkOutput("c3_rd_hold",   32'(consumer_read_ready),   32'h08);
        applyStimulus(3, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tick();
        checkQuiet("c3_release");

        // All eight consumers read at once over four channels
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            req_addr[i] = 8'($urandom);
            applyStimulus(i, 1'b1, req_addr[i], 1'b0, 8'h00, 8'h00);
        end
        for (int r = 0; r < 2; r++) begin
            tick();
            checkOutput($sformatf("all_mem_rd_v_r%0d", r), 32'(mem_read_valid), 32'hF);
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                checkOutput($sformatf("all_addr_r%0d_ch%0d", r, ch),
                            32'(mem_read_address[ch]), 32'(req_addr[r*4+ch]));
                mem_read_ready[ch] = 1'b1;
                mem_read_data[ch]  = mem_model[req_addr[r*4+ch]];
            end
            tick();
            mem_read_ready = '0;
            checkOutput($sformatf("all_rd_ready_r%0d", r), 32'(consumer_read_ready),
                        32'(8'h0F << (r*4)));
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                checkOutput($sformatf("all_rd_data_c%0d", r*4+ch),
                            32'(consumer_read_data[r*4+ch]), 32'(mem_model[req_addr[r*4+ch]]));
                applyStimulus(r*4+ch, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
            end
            tick();
            checkQuiet($sformatf("all_release_r%0d", r));
        end

        // Consumer 5: simultaneous read 0x12 and write 0x11 <- 0xAB
        applyStimulus(5, 1'b1, 8'h12, 1'b1, 8'h11, 8'hAB);
        tick();
        checkOutput("c5_mem_rd_v",   32'(mem_read_valid),      32'h1);
        checkOutput("c5_mem_rd_a",   32'(mem_read_address[0]), 32'h12);
        checkOutput("c5_no_write",   32'(mem_write_valid),     32'h0);
        mem_read_ready[0] = 1'b1;
        mem_read_data[0]  = mem_model[8'h12];
        tick();
        mem_read_ready[0] = 1'b0;
        checkOutput("c5_rd_ready",   32'(consumer_read_ready),   32'h20);
        checkOutput("c5_rd_data",    32'(consumer_read_data[5]), 32'(mem_model[8'h12]));
        checkOutput("c5_wr_ready0",  32'(consumer_write_ready),  32'h0);
        consumer_read_valid[5] = 1'b0;
        tick();
        checkQuiet("c5_read_released");
        tick();
        checkOutput("c5_mem_wr_v",   32'(mem_write_valid),      32'h1);
        checkOutput("c5_mem_wr_a",   32'(mem_write_address[0]), 32'h11);
        checkOutput("c5_mem_wr_d",   32'(mem_write_data[0]),    32'hAB);
        mem_write_ready[0] = 1'b1;
        tick();
        mem_write_ready[0] = 1'b0;
        mem_model[8'h11] = 8'hAB;
        checkOutput("c5_wr_ready",   32'(consumer_write_ready), 32'h20);
        checkOutput("c5_mem_wr_v0",  32'(mem_write_valid),      32'h0);
        applyStimulus(5, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tick();
        checkQuiet("c5_write_released");

        // Asynchronous reset while channel 0 waits on memory, then clean re-claim
        a = 8'($urandom);
        applyStimulus(2, 1'b1, a, 1'b0, 8'h00, 8'h00);
        tick();
        checkOutput("rst_mem_rd_v", 32'(mem_read_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        checkQuiet("rst_async");
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rst_reclaim_v", 32'(mem_read_valid),      32'h1);
        checkOutput("rst_reclaim_a", 32'(mem_read_address[0]), 32'(a));
        mem_read_ready[0] = 1'b1;
        mem_read_data[0]  = mem_model[a];
        tick();
        mem_read_ready[0] = 1'b0;
        checkOutput("rst_rd_data", 32'(consumer_read_data[2]), 32'(mem_model[a]));
        applyStimulus(2, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tick();
        checkQuiet("rst_released");

        // Stray memory ready on an idle channel
        mem_read_ready[2] = 1'b1;
        mem_read_data[2]  = 8'hEE;
        tick();
        mem_read_ready[2] = 1'b0;
        checkQuiet("stray_ready");
        tick();
        checkQuiet("stray_ready_after");

        // Consumer drops valid while its request is still waiting on memory
        a = 8'($urandom);
        applyStimulus(6, 1'b1, a, 1'b0, 8'h00, 8'h00);
        tick();
        consumer_read_valid[6] = 1'b0;
        tick();
        mem_read_ready[0] = 1'b1;
        mem_read_data[0]  = mem_model[a];
        tick();
        mem_read_ready[0] = 1'b0;
        checkOutput("drop_pulse", 32'(consumer_read_ready), 32'h40);
        tick();
        checkQuiet("drop_after_pulse");

        // Randomised single transactions against the memory model
        for (int i = 0; i < 12; i++) begin
            c        = int'($urandom_range(NUM_CONSUMERS - 1));
            a        = 8'($urandom_range(15));
            d        = 8'($urandom);
            is_write = 1'($urandom_range(1));
            lat      = int'($urandom_range(3));
            if (is_write) applyStimulus(c, 1'b0, 8'h00, 1'b1, a, d);
            else          applyStimulus(c, 1'b1, a, 1'b0, 8'h00, 8'h00);
            tick();
            if (is_write) begin
                checkOutput($sformatf("rnd%0d_wr_v", i), 32'(mem_write_valid),      32'h1);
                checkOutput($sformatf("rnd%0d_wr_a", i), 32'(mem_write_address[0]), 32'(a));
                checkOutput($sformatf("rnd%0d_wr_d", i), 32'(mem_write_data[0]),    32'(d));
            end else begin
                checkOutput($sformatf("rnd%0d_rd_v", i), 32'(mem_read_valid),      32'h1);
                checkOutput($sformatf("rnd%0d_rd_a", i), 32'(mem_read_address[0]), 32'(a));
            end
            tick(lat);
            if (is_write) begin
                mem_write_ready[0] = 1'b1;
            end else begin
                mem_read_ready[0] = 1'b1;
                mem_read_data[0]  = mem_model[a];
            end
            tick();
            mem_write_ready[0] = 1'b0;
            mem_read_ready[0]  = 1'b0;
            if (is_write) begin
                mem_model[a] = d;
                checkOutput($sformatf("rnd%0d_wr_ready", i), 32'(consumer_write_ready),
                            32'(8'h01 << c));
            end else begin
                checkOutput($sformatf("rnd%0d_rd_ready", i), 32'(consumer_read_ready),
                            32'(8'h01 << c));
                checkOutput($sformatf("rnd%0d_rd_data", i), 32'(consumer_read_data[c]),
                            32'(mem_model[a]));
            end
            applyStimulus(c, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
            tick();
            checkQuiet($sformatf("rnd%0d_release", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
